seq_pattern_detector: RTL and testbench

Parametrised serial pattern detector, the successor to the team's fixed 3-ones run detector FSMs. It watches a qualified 1-bit input stream and pulses `match` whenever the last `cfg_len` accepted bits equal a runtime-programmed pattern. It supports overlapping and non-overlapping modes and keeps a saturating match counter. It sits on serial control/status lines, e.g. as a framing-sync or preamble detector ahead of a deserialiser.

---
 rtl/seq_pattern_detector_if.sv | 30 +++
 rtl/seq_pattern_detector.sv | 155 +++++++++++++++
 tb/tb_seq_pattern_detector.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_detector_if.sv
// Bus between a serial-pattern-detector client and the detector: configuration,
// the qualified bit stream and match/status outputs.
interface seq_pattern_detector_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
);
    logic             i_cfg_load;
    logic [PAT_W-1:0] i_cfg_pattern;
    logic [LEN_W-1:0] i_cfg_len;
    logic             i_cfg_overlap;
    logic             i_in_valid;
    logic             i_in_bit;
    logic             o_match;
    logic [CNT_W-1:0] o_match_count;
    logic             o_count_sat;
    logic             o_armed;

    modport master (
        output i_cfg_load, i_cfg_pattern, i_cfg_len, i_cfg_overlap,
        output i_in_valid, i_in_bit,
        input  o_match, o_match_count, o_count_sat, o_armed
    );

    modport slave (
        input  i_cfg_load, i_cfg_pattern, i_cfg_len, i_cfg_overlap,
        input  i_in_valid, i_in_bit,
        output o_match, o_match_count, o_count_sat, o_armed
    );
endinterface

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector with overlap control and a
// saturating match counter; all outputs are registered.
module seq_pattern_detector #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_pattern_detector_if.slave bus
);

    typedef enum logic [1:0] {
        ST_UNCFG = 2'd0,
        ST_FILL  = 2'd1,
        ST_ARMED = 2'd2
    } state_e;

    // Only PAT_W-1 past bits are stored: the oldest one is shifted out before
    // any comparison could see it, since matching uses the post-shift history.
    state_e           r_state;
    logic [PAT_W-2:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_ovl;
    logic             r_match;
    logic [CNT_W-1:0] r_count;
    logic             r_sat;

    state_e           w_state_nxt;
    logic [PAT_W-2:0] w_hist_nxt;
    logic [LEN_W-1:0] w_fill_nxt;
    logic [PAT_W-1:0] w_pat_nxt;
    logic [LEN_W-1:0] w_len_nxt;
    logic             w_ovl_nxt;
    logic             w_match_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_sat_nxt;

    logic [PAT_W-1:0] w_shift;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W-1:0] w_len_clamped;
    logic             w_hit;
    logic             w_eval;

    assign w_shift       = {r_hist, bus.i_in_bit};
    assign w_len_clamped = (bus.i_cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.i_cfg_len;

    always_comb begin
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
    end

    // A zero length never matches even though an empty mask compares equal.
    assign w_hit = (r_len != '0) && (((w_shift ^ r_pat) & w_mask) == '0);

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_hist_nxt  = r_hist;
        w_fill_nxt  = r_fill;
        w_pat_nxt   = r_pat;
        w_len_nxt   = r_len;
        w_ovl_nxt   = r_ovl;
        w_match_nxt = 1'b0;
        w_count_nxt = r_count;
        w_sat_nxt   = r_sat;
        w_eval      = 1'b0;

        if (bus.i_cfg_load) begin
            w_pat_nxt   = bus.i_cfg_pattern;
            w_len_nxt   = w_len_clamped;
            w_ovl_nxt   = bus.i_cfg_overlap;
            w_hist_nxt  = '0;
            w_fill_nxt  = '0;
            w_count_nxt = '0;
            w_sat_nxt   = 1'b0;
            w_state_nxt = ST_FILL;
        end else if (bus.i_in_valid) begin
            unique case (r_state)
                ST_FILL: begin
                    // With L = 0 nothing is ever collected and fill stays at 0.
                    if (r_len != '0) begin
                        w_hist_nxt = w_shift[PAT_W-2:0];
                        w_fill_nxt = r_fill + 1'b1;
                        if (w_fill_nxt == r_len) begin
                            w_state_nxt = ST_ARMED;
                            w_eval      = 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    w_hist_nxt = w_shift[PAT_W-2:0];
                    w_eval     = 1'b1;
                end
                default: ;
            endcase

            if (w_eval && w_hit) begin
                w_match_nxt = 1'b1;
                if (&r_count) begin
                    w_sat_nxt = 1'b1;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
                if (!r_ovl) begin
                    w_hist_nxt  = '0;
                    w_fill_nxt  = '0;
                    w_state_nxt = ST_FILL;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_UNCFG;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= '0;
            r_len   <= '0;
            r_ovl   <= 1'b0;
            r_match <= 1'b0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_hist  <= w_hist_nxt;
            r_fill  <= w_fill_nxt;
            r_pat   <= w_pat_nxt;
            r_len   <= w_len_nxt;
            r_ovl   <= w_ovl_nxt;
            r_match <= w_match_nxt;
            r_count <= w_count_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    assign bus.o_match       = r_match;
    assign bus.o_match_count = r_count;
    assign bus.o_count_sat   = r_sat;
    assign bus.o_armed       = (r_state == ST_ARMED);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector: overlap modes, gaps, counter
// saturation, load/bit collision, length clamp, L = 0 and mid-stream reset.
module tb_seq_pattern_detector;

    localparam int PAT_W = 8;
    localparam int CNT_W = 4;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    seq_pattern_detector_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic cycle(input logic load, input logic valid, input logic b);
        @(negedge clk);
        bus.i_cfg_load = load;
        bus.i_in_valid = valid;
        bus.i_in_bit   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                            input logic ovl);
        @(negedge clk);
        bus.i_cfg_pattern = pat;
        bus.i_cfg_len     = len;
        bus.i_cfg_overlap = ovl;
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic send(input string tag, input logic b, input logic em, input int ec,
                        input logic ea, input logic es = 1'b0);
        cycle(1'b0, 1'b1, b);
        check({tag, ".match"}, 32'(bus.o_match), 32'(em));
        check({tag, ".count"}, 32'(bus.o_match_count), 32'(ec));
        check({tag, ".armed"}, 32'(bus.o_armed), 32'(ea));
        check({tag, ".sat"}, 32'(bus.o_count_sat), 32'(es));
    endtask

    task automatic gap(input string tag, input int n, input int ec);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            check({tag, ".gap_match"}, 32'(bus.o_match), 32'd0);
            check({tag, ".gap_count"}, 32'(bus.o_match_count), 32'(ec));
        end
    endtask

    initial begin
        logic [7:0] clamp_pat;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.i_cfg_load    = 1'b0;
        bus.i_cfg_pattern = '0;
        bus.i_cfg_len     = '0;
        bus.i_cfg_overlap = 1'b0;
        bus.i_in_valid    = 1'b0;
        bus.i_in_bit      = 1'b0;

        // Reset values
        #12;
        check("rst.match", 32'(bus.o_match), 32'd0);
        check("rst.count", 32'(bus.o_match_count), 32'd0);
        check("rst.sat", 32'(bus.o_count_sat), 32'd0);
        check("rst.armed", 32'(bus.o_armed), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unconfigured: bits are ignored
        send("uncfg1", 1'b1, 1'b0, 0, 1'b0);
        send("uncfg2", 1'b1, 1'b0, 0, 1'b0);
        send("uncfg3", 1'b1, 1'b0, 0, 1'b0);

        // 111, L=3, overlap: stream 1,1,1,1,0,1
        load_cfg(8'b111, 4'd3, 1'b1);
        check("ovl.load_armed", 32'(bus.o_armed), 32'd0);
        send("ovl.b1", 1'b1, 1'b0, 0, 1'b0);
        send("ovl.b2", 1'b1, 1'b0, 0, 1'b0);
        send("ovl.b3", 1'b1, 1'b1, 1, 1'b1);
        send("ovl.b4", 1'b1, 1'b1, 2, 1'b1);
        send("ovl.b5", 1'b0, 1'b0, 2, 1'b1);
        send("ovl.b6", 1'b1, 1'b0, 2, 1'b1);

        // 111, L=3, no overlap: stream six ones
        load_cfg(8'b111, 4'd3, 1'b0);
        check("novl.load_count", 32'(bus.o_match_count), 32'd0);
        send("novl.b1", 1'b1, 1'b0, 0, 1'b0);
        send("novl.b2", 1'b1, 1'b0, 0, 1'b0);
        send("novl.b3", 1'b1, 1'b1, 1, 1'b0);
        send("novl.b4", 1'b1, 1'b0, 1, 1'b0);
        send("novl.b5", 1'b1, 1'b0, 1, 1'b0);
        send("novl.b6", 1'b1, 1'b1, 2, 1'b0);

        // 101, L=3, overlap, two idle cycles between bits
        load_cfg(8'b101, 4'd3, 1'b1);
        send("gap.b1", 1'b1, 1'b0, 0, 1'b0);
        gap("gap.g1", 2, 0);
        send("gap.b2", 1'b0, 1'b0, 0, 1'b0);
        gap("gap.g2", 2, 0);
        send("gap.b3", 1'b1, 1'b1, 1, 1'b1);
        gap("gap.g3", 2, 1);
        send("gap.b4", 1'b0, 1'b0, 1, 1'b1);
        gap("gap.g4", 2, 1);
        send("gap.b5", 1'b1, 1'b1, 2, 1'b1);
        gap("gap.g5", 2, 2);

        // Saturation: pattern 1, L=1, 17 ones on a 4-bit counter
        load_cfg(8'b1, 4'd1, 1'b1);
        for (int i = 1; i <= 17; i++) begin
            send($sformatf("sat.b%0d", i), 1'b1, 1'b1, (i < 15) ? i : 15, 1'b1, 1'(i >= 16));
        end
        gap("sat.after", 1, 15);
        check("sat.sticky", 32'(bus.o_count_sat), 32'd1);

        // Load collides with a bit that would complete 111; new L=11 clamps to 8
        load_cfg(8'b111, 4'd3, 1'b1);
        send("col.b1", 1'b1, 1'b0, 0, 1'b0);
        send("col.b2", 1'b1, 1'b0, 0, 1'b0);
        clamp_pat = 8'b1010_0101;
        @(negedge clk);
        bus.i_cfg_pattern = clamp_pat;
        bus.i_cfg_len     = 4'(PAT_W + 3);
        bus.i_cfg_overlap = 1'b1;
        cycle(1'b1, 1'b1, 1'b1);
        check("col.match", 32'(bus.o_match), 32'd0);
        check("col.count", 32'(bus.o_match_count), 32'd0);
        check("col.armed", 32'(bus.o_armed), 32'd0);
        for (int i = 7; i >= 1; i--) begin
            send($sformatf("clamp.b%0d", 8 - i), clamp_pat[i], 1'b0, 0, 1'b0);
        end
        send("clamp.b8", clamp_pat[0], 1'b1, 1, 1'b1);

        // L = 0 never matches, stays out of ARMED
        load_cfg(8'b0, 4'd0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            send($sformatf("len0.b%0d", i), 1'b0, 1'b0, 0, 1'b0);
        end

        // Reset during a match pulse
        load_cfg(8'b1, 4'd1, 1'b1);
        send("rstm.b1", 1'b1, 1'b1, 1, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rstm.match", 32'(bus.o_match), 32'd0);
        check("rstm.count", 32'(bus.o_match_count), 32'd0);
        check("rstm.armed", 32'(bus.o_armed), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send("rstm.post1", 1'b1, 1'b0, 0, 1'b0);
        send("rstm.post2", 1'b1, 1'b0, 0, 1'b0);
        send("rstm.post3", 1'b1, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
